// File: rtl/aes_kat_bist.sv
// ---------------------------------------------------------------------------
// aes_kat_bist
// Known-answer self-test engine for the pipelined aes_128 core. It streams a
// small ROM of (state, key, expected) vectors, one per cycle. A delay line of
// {valid, idx, expected} tracks each launched vector until the core result
// arrives, and the result is then compared against the expected value.
//
// Ports
//   clk        in   1       sole clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   start      in   1       level; sampled only when idle / done
//   dut_state  out  DATA_W  registered plaintext to aes_128.state
//   dut_key    out  DATA_W  registered key to aes_128.key
//   dut_out    in   DATA_W  aes_128.out
//   busy       out  1       run in progress (launching or waiting)
//   done       out  1       run complete
//   pass       out  1       valid while done: no mismatches
//   fail_idx   out  IDX_W   index of first mismatch (0 if none)
//   err_count  out  ERR_W   mismatch count, saturating
//
// Build option AES_BIST_CONTINUOUS_EN: the run loops while start is held,
// done pulses once per pass, and the error state accumulates across passes
// (cleared only by reset or a start accepted from idle).
// ---------------------------------------------------------------------------
module aes_kat_bist #(
    parameter int DATA_W  = 128,
    parameter int LATENCY = 20,
    parameter int NUM_VEC = 5,
    parameter int IDX_W   = 3,
    parameter int ERR_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [DATA_W-1:0] dut_state,
    output logic [DATA_W-1:0] dut_key,
    input  logic [DATA_W-1:0] dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [ERR_W-1:0]  err_count
);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

    function automatic logic [DATA_W-1:0] rom_state(input logic [IDX_W-1:0] i);
        case (int'(i))
            0:       return DATA_W'(128'h3243f6a8885a308d313198a2e0370734);
            1:       return DATA_W'(128'h00112233445566778899aabbccddeeff);
            4:       return DATA_W'(128'h1);
            default: return '0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] rom_key(input logic [IDX_W-1:0] i);
        case (int'(i))
            0:       return DATA_W'(128'h2b7e151628aed2a6abf7158809cf4f3c);
            1:       return DATA_W'(128'h000102030405060708090a0b0c0d0e0f);
            3:       return DATA_W'(128'h1);
            default: return '0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] rom_exp(input logic [IDX_W-1:0] i);
        case (int'(i))
            0:       return DATA_W'(128'h3925841d02dc09fbdc118597196a0b32);
            1:       return DATA_W'(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
            2:       return DATA_W'(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
            3:       return DATA_W'(128'h0545aad56da2a97c3663d1432a3d1c84);
            4:       return DATA_W'(128'h58e2fccefa7e3061367f1d57a4e7455a);
            default: return '0;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             launch;
    logic             clr;

    // Launch register sits alongside dut_state/dut_key; the delay line
    // (stages 0..LATENCY) follows it, so the last stage lines up with the
    // first edge at which the core result for that vector is valid.
    logic              ln_v;
    logic [IDX_W-1:0]  ln_idx;
    logic [DATA_W-1:0] ln_exp;
    logic              dl_v   [0:LATENCY];
    logic [IDX_W-1:0]  dl_idx [0:LATENCY];
    logic [DATA_W-1:0] dl_exp [0:LATENCY];

    logic cmp_v, cmp_last, mismatch;

    assign cmp_v    = dl_v[LATENCY];
    assign cmp_last = cmp_v && (dl_idx[LATENCY] == LAST_IDX);
    assign mismatch = cmp_v && (dut_out != dl_exp[LATENCY]);
    assign pass     = done && (err_count == '0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        launch  = 1'b0;
        clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    idx_d   = '0;
                    launch  = 1'b1;
                    clr     = 1'b1;
                end
            end
            S_DRIVE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_WAIT;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    launch = 1'b1;
                end
            end
            S_WAIT: begin
                if (cmp_last) state_d = S_DONE;
            end
            S_DONE: begin
`ifdef AES_BIST_CONTINUOUS_EN
                // Relaunch keeps the accumulated error state; dropping start
                // lets the finished pass retire to idle.
                if (start) begin
                    state_d = S_DRIVE;
                    idx_d   = '0;
                    launch  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
`else
                if (start) begin
                    state_d = S_DRIVE;
                    idx_d   = '0;
                    launch  = 1'b1;
                    clr     = 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            dut_state <= '0;
            dut_key   <= '0;
            ln_v      <= 1'b0;
            ln_idx    <= '0;
            ln_exp    <= '0;
            err_count <= '0;
            fail_idx  <= '0;
            for (int unsigned k = 0; k <= LATENCY; k++) begin
                dl_v[k]   <= 1'b0;
                dl_idx[k] <= '0;
                dl_exp[k] <= '0;
            end
        end else begin
            busy      <= (state_d == S_DRIVE) || (state_d == S_WAIT);
            done      <= (state_d == S_DONE);
            dut_state <= launch ? rom_state(idx_d) : '0;
            dut_key   <= launch ? rom_key(idx_d)   : '0;
            ln_v      <= launch;
            ln_idx    <= idx_d;
            ln_exp    <= rom_exp(idx_d);

            dl_v[0]   <= ln_v;
            dl_idx[0] <= ln_idx;
            dl_exp[0] <= ln_exp;
            for (int unsigned k = 1; k <= LATENCY; k++) begin
                dl_v[k]   <= dl_v[k-1];
                dl_idx[k] <= dl_idx[k-1];
                dl_exp[k] <= dl_exp[k-1];
            end

            // A start is only accepted once the delay line has drained, so
            // clearing and counting never coincide.
            if (clr) begin
                err_count <= '0;
                fail_idx  <= '0;
            end else if (mismatch) begin
                if (err_count != '1) err_count <= err_count + 1'b1;
                if (err_count == '0) fail_idx  <= dl_idx[LATENCY];
            end
        end
    end

endmodule
